stage4_mem: RTL and testbench

//  MEM stage of the 5-stage pipeline; consumes the registered EX/MEM outputs (ALU result, store data,

---
 rtl/stage4_mem_pkg.sv | 39 +++
 rtl/stage4_mem_dmem_handshake.sv | 102 ++++++++++
 rtl/stage4_mem.sv | 114 +++++++++++
 tb/tb_stage4_mem.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_mem_pkg.sv
// Shared definitions for the MEM stage: branch encodings, handshake FSM states,
// timeout fill value and the branch-resolution helper.
package stage4_mem_pkg;

    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned RW          = 5;

    // Load data returned to WB when an access is aborted by timeout
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_GT   = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } hs_state_e;

    // Branch condition from the EX flags
    function automatic logic br_taken(input logic [1:0] br, input logic z,
                                      input logic nz, input logic gt);
        logic t;
        t = 1'b0;
        case (br_type_e'(br))
            BR_EQ:   t = z;
            BR_NE:   t = nz;
            BR_GT:   t = gt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/stage4_mem_dmem_handshake.sv
// Data-memory request/ack handshake for the MEM stage.
// IDLE/WAIT FSM producing request, stall, completion and (optionally) timeout.
// Optional feature: DMEM_TIMEOUT_EN enables the WAIT-cycle counter and sticky error.
// Ports:
//   i_clk, i_rstb   clock, async active-high reset
//   i_start         EX/MEM holds a valid load/store
//   i_ack           memory access done
//   o_req_c         request (combinational)
//   o_stall_c       hold the pipe: request outstanding, not acked, not timing out
//   o_done_c        access completed by ack this cycle
//   o_timeout_c     access aborted by timeout this cycle
//   o_err           sticky timeout flag (registered)
module stage4_mem_dmem_handshake
    import stage4_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rstb,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req_c,
    output logic o_stall_c,
    output logic o_done_c,
    output logic o_timeout_c,
    output logic o_err
);

    hs_state_e r_state;
    hs_state_e w_next;
    logic      w_req;
    logic      w_done;
    logic      w_timeout;
    logic      w_to_hit;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Request cycle counts as the first; abort on the TIMEOUT_CYC-th un-acked cycle
    assign w_to_hit = (r_cnt == CW'(TIMEOUT_CYC - 1));

    // Counts consecutive un-acked request cycles
    always_ff @(posedge i_clk or posedge i_rstb) begin
        if (i_rstb) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (w_next == ST_WAIT) ? r_cnt + CW'(1) : '0;
            r_err <= r_err | w_timeout;
        end
    end

    assign o_err = r_err;
`else
    assign w_to_hit = 1'b0;
    assign o_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rstb) begin
        if (i_rstb) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_req = 1'b1;
                    if (i_ack) w_done = 1'b1;
                    else       w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (i_ack) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Reset drops the request in the same cycle it is asserted
    assign o_req_c     = w_req & ~i_rstb;
    assign o_done_c    = w_done & ~i_rstb;
    assign o_timeout_c = w_timeout & ~i_rstb;
    assign o_stall_c   = o_req_c & ~i_ack & ~w_timeout;

endmodule

// File: rtl/stage4_mem.sv
// MEM stage of the 5-stage pipeline: drives the data-memory port, resolves
// branches for IF, stalls the pipe on outstanding accesses and registers MEM/WB.
// Optional feature: DMEM_TIMEOUT_EN (abort un-acked accesses, sticky o_dmem_err).
// Ports:
//   i_clk, i_rstb                          clock, async active-high reset
//   i_ex_valid .. i_mem_to_reg             registered EX/MEM bundle
//   o_dmem_req/we/addr/wdata, i_dmem_rdata/ack   data-memory port
//   o_mem_stall                            freeze IF..EX, hold EX/MEM
//   o_pc_src, o_branch_target              branch resolution (combinational)
//   o_*_wb                                 registered MEM/WB bundle
//   o_dmem_err                             sticky timeout flag
module stage4_mem
    import stage4_mem_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic          i_ex_valid,
    input  logic [DW-1:0] i_alu_result,
    input  logic [DW-1:0] i_regb_rd_data,
    input  logic [RW-1:0] i_reg_wr_addr,
    input  logic          i_alu_zero,
    input  logic          i_alu_not_zero,
    input  logic          i_alu_greater,
    input  logic [DW-1:0] i_pc_plus4_plusimm16,
    input  logic          i_mem_read,
    input  logic          i_mem_write,
    input  logic [1:0]    i_br_type,
    input  logic          i_reg_write,
    input  logic          i_mem_to_reg,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    output logic [AW-1:0] o_dmem_addr,
    output logic [DW-1:0] o_dmem_wdata,
    input  logic [DW-1:0] i_dmem_rdata,
    input  logic          i_dmem_ack,
    output logic          o_mem_stall,
    output logic          o_pc_src,
    output logic [DW-1:0] o_branch_target,
    output logic [DW-1:0] o_mem_rd_data_wb,
    output logic [DW-1:0] o_alu_result_wb,
    output logic [RW-1:0] o_reg_wr_addr_wb,
    output logic          o_reg_write_wb,
    output logic          o_mem_to_reg_wb,
    output logic          o_dmem_err
);

    logic w_memop;
    logic w_is_load;
    logic w_req;
    logic w_stall;
    logic w_done;
    logic w_timeout;
    logic w_alu_done;

    assign w_memop   = i_mem_read | i_mem_write;
    // Read and write together is treated as a store
    assign w_is_load = i_mem_read & ~i_mem_write;

    stage4_mem_dmem_handshake #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_hs (
        .i_clk       (i_clk),
        .i_rstb      (i_rstb),
        .i_start     (i_ex_valid & w_memop),
        .i_ack       (i_dmem_ack),
        .o_req_c     (w_req),
        .o_stall_c   (w_stall),
        .o_done_c    (w_done),
        .o_timeout_c (w_timeout),
        .o_err       (o_dmem_err)
    );

    assign o_dmem_req      = w_req;
    assign o_dmem_we       = i_mem_write;
    assign o_dmem_addr     = i_alu_result[AW-1:0];
    assign o_dmem_wdata    = i_regb_rd_data;
    assign o_mem_stall     = w_stall;
    assign o_pc_src        = i_ex_valid &
                             br_taken(i_br_type, i_alu_zero, i_alu_not_zero, i_alu_greater);
    assign o_branch_target = i_pc_plus4_plusimm16;

    // Non-memory instructions complete in the cycle they are presented
    assign w_alu_done = i_ex_valid & ~w_memop & ~w_req;

    // MEM/WB register: load on completion, bubble (reg_write=0) otherwise
    always_ff @(posedge i_clk or posedge i_rstb) begin
        if (i_rstb) begin
            o_mem_rd_data_wb <= '0;
            o_alu_result_wb  <= '0;
            o_reg_wr_addr_wb <= '0;
            o_reg_write_wb   <= 1'b0;
            o_mem_to_reg_wb  <= 1'b0;
        end else if (w_timeout) begin
            o_mem_rd_data_wb <= DW'(DEADBEEF);
            o_alu_result_wb  <= i_alu_result;
            o_reg_wr_addr_wb <= i_reg_wr_addr;
            o_reg_write_wb   <= 1'b0;
            o_mem_to_reg_wb  <= i_mem_to_reg;
        end else if (w_done || w_alu_done) begin
            if (w_done && w_is_load) o_mem_rd_data_wb <= i_dmem_rdata;
            o_alu_result_wb  <= i_alu_result;
            o_reg_wr_addr_wb <= i_reg_wr_addr;
            o_reg_write_wb   <= i_reg_write;
            o_mem_to_reg_wb  <= i_mem_to_reg;
        end else begin
            o_reg_write_wb   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage4_mem.sv
module tb_stage4_mem;

    logic        clk;
    logic        rstb;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] regb_rd_data;
    logic [4:0]  reg_wr_addr;
    logic        alu_zero, alu_not_zero, alu_greater;
    logic [31:0] pc_target;
    logic        mem_read, mem_write;
    logic [1:0]  br_type;
    logic        reg_write, mem_to_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall, pc_src;
    logic [31:0] branch_target, mem_rd_data_wb, alu_result_wb;
    logic [4:0]  reg_wr_addr_wb;
    logic        reg_write_wb, mem_to_reg_wb, dmem_err;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
    } wb_t;

    wb_t         q[$];
    wb_t         exp_wb;
    wb_t         last_wb;
    logic [31:0] mdl_rdata;
    int          total;
    int          bad;

    stage4_mem dut (
        .i_clk                (clk),
        .i_rstb               (rstb),
        .i_ex_valid           (ex_valid),
        .i_alu_result         (alu_result),
        .i_regb_rd_data       (regb_rd_data),
        .i_reg_wr_addr        (reg_wr_addr),
        .i_alu_zero           (alu_zero),
        .i_alu_not_zero       (alu_not_zero),
        .i_alu_greater        (alu_greater),
        .i_pc_plus4_plusimm16 (pc_target),
        .i_mem_read           (mem_read),
        .i_mem_write          (mem_write),
        .i_br_type            (br_type),
        .i_reg_write          (reg_write),
        .i_mem_to_reg         (mem_to_reg),
        .o_dmem_req           (dmem_req),
        .o_dmem_we            (dmem_we),
        .o_dmem_addr          (dmem_addr),
        .o_dmem_wdata         (dmem_wdata),
        .i_dmem_rdata         (dmem_rdata),
        .i_dmem_ack           (dmem_ack),
        .o_mem_stall          (mem_stall),
        .o_pc_src             (pc_src),
        .o_branch_target      (branch_target),
        .o_mem_rd_data_wb     (mem_rd_data_wb),
        .o_alu_result_wb      (alu_result_wb),
        .o_reg_wr_addr_wb     (reg_wr_addr_wb),
        .o_reg_write_wb       (reg_write_wb),
        .o_mem_to_reg_wb      (mem_to_reg_wb),
        .o_dmem_err           (dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_t obs_wb();
        wb_t o;
        o = '{alu: alu_result_wb, rd: reg_wr_addr_wb, rw: reg_write_wb,
              m2r: mem_to_reg_wb, rdata: mem_rd_data_wb};
        return o;
    endfunction

    task automatic drive_idle();
        ex_valid = 0; alu_result = 0; regb_rd_data = 0; reg_wr_addr = 0;
        alu_zero = 0; alu_not_zero = 0; alu_greater = 0; pc_target = 0;
        mem_read = 0; mem_write = 0; br_type = 0; reg_write = 0; mem_to_reg = 0;
        dmem_rdata = 0; dmem_ack = 0;
    endtask

    task automatic drive_instr(input logic [31:0] a, input logic [4:0] rd, input logic rw,
                               input logic rd_m, input logic wr_m, input logic m2r);
        ex_valid = 1; alu_result = a; reg_wr_addr = rd; reg_write = rw;
        mem_read = rd_m; mem_write = wr_m; mem_to_reg = m2r;
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic test_reset();
        rstb = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++; $display("FAIL reset_req: req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        total++;
        if (obs_wb() !== wb_t'(0)) begin
            bad++; $display("FAIL reset_wb: got %h exp 0", obs_wb());
        end
        total++;
        if (dmem_err !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b exp 0", dmem_err);
        end
        rstb = 0;
        mdl_rdata = 0;
        last_wb = '0;
    endtask

    task automatic test_alu();
        drive_instr(32'h15, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        q.push_back('{alu: 32'h15, rd: 5'd3, rw: 1'b1, m2r: 1'b0, rdata: mdl_rdata});
        #3;
        total++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++; $display("FAIL alu_noreq: req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        @(posedge clk); #1;
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL alu_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_instr(32'(i * 32'h11 + 1), 5'(i + 1), (i != 2), 1'b0, 1'b0, 1'b0);
            q.push_back('{alu: 32'(i * 32'h11 + 1), rd: 5'(i + 1), rw: (i != 2),
                          m2r: 1'b0, rdata: mdl_rdata});
            @(posedge clk); #1;
            exp_wb = q.pop_front();
            total++;
            if (obs_wb() !== exp_wb) begin
                bad++; $display("FAIL b2b_wb%0d: got %h exp %h", i, obs_wb(), exp_wb);
            end
            last_wb = exp_wb;
        end
        // Bubble with stray ack: no request, WB fields hold, reg_write clears
        drive_idle();
        reg_write = 1; alu_result = 32'h777; dmem_ack = 1;
        exp_wb = last_wb; exp_wb.rw = 1'b0;
        q.push_back(exp_wb);
        #3;
        total++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++; $display("FAIL idle_ack: req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        @(posedge clk); #1;
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL bubble_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask

    task automatic test_load_wait();
        int  nstall;
        bit  done;
        nstall = 0;
        done   = 0;
        drive_instr(32'h40, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        mdl_rdata = 32'hCAFE0001;
        q.push_back('{alu: 32'h40, rd: 5'd7, rw: 1'b1, m2r: 1'b1, rdata: mdl_rdata});
        for (int c = 0; c < 20 && !done; c++) begin
            if (c == 3) begin dmem_ack = 1; dmem_rdata = 32'hCAFE0001; end
            #3;
            if (mem_stall === 1'b1) nstall++;
            total++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h40 || dmem_we !== 1'b0) begin
                bad++; $display("FAIL load_req c%0d: req=%b addr=%h we=%b exp 1 40 0",
                                c, dmem_req, dmem_addr, dmem_we);
            end
            done = (dmem_ack === 1'b1);
            @(posedge clk); #1;
            if (!done) begin
                total++;
                if (reg_write_wb !== 1'b0) begin
                    bad++; $display("FAIL load_bubble c%0d: reg_write_wb=%b exp 0", c, reg_write_wb);
                end
            end
        end
        total++;
        if (nstall != 3) begin
            bad++; $display("FAIL load_stall_cycles: got %0d exp 3", nstall);
        end
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL load_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask

    task automatic test_store();
        // Read and write both set: store, load data must not be captured
        drive_instr(32'h80, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        regb_rd_data = 32'h1234_5678;
        dmem_rdata   = 32'hBAD0_BAD0;
        dmem_ack     = 1;
        q.push_back('{alu: 32'h80, rd: 5'd2, rw: 1'b0, m2r: 1'b0, rdata: mdl_rdata});
        #3;
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL store_port: req=%b we=%b wdata=%h exp 1 1 12345678",
                            dmem_req, dmem_we, dmem_wdata);
        end
        total++;
        if (mem_stall !== 1'b0) begin
            bad++; $display("FAIL store_stall: got %b exp 0", mem_stall);
        end
        @(posedge clk); #1;
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL store_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask

    task automatic test_branch();
        // {valid, br, z, nz, gt, expected pc_src}
        logic [6:0] tbl [0:6];
        logic [6:0] e;
        tbl[0] = {1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = {1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = {1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = {1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = {1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = {1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            e = tbl[i];
            drive_idle();
            ex_valid = e[6]; br_type = e[5:4];
            alu_zero = e[3]; alu_not_zero = e[2]; alu_greater = e[1];
            pc_target = 32'h1000 + 32'(i * 4);
            #3;
            total++;
            if (pc_src !== e[0] || branch_target !== 32'h1000 + 32'(i * 4)) begin
                bad++; $display("FAIL branch%0d: pc_src=%b tgt=%h exp %b %h",
                                i, pc_src, branch_target, e[0], 32'h1000 + 32'(i * 4));
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_wait();
        drive_instr(32'h44, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rstb = 1;
        #1;
        total++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++; $display("FAIL rst_wait_req: req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        total++;
        if (obs_wb() !== wb_t'(0)) begin
            bad++; $display("FAIL rst_wait_wb: got %h exp 0", obs_wb());
        end
        mdl_rdata = 0;
        @(posedge clk); #1;
        rstb = 0;
        dmem_ack = 1; dmem_rdata = 32'h5A5A_0002;
        mdl_rdata = 32'h5A5A_0002;
        q.push_back('{alu: 32'h44, rd: 5'd9, rw: 1'b1, m2r: 1'b1, rdata: mdl_rdata});
        #2;
        total++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
            bad++; $display("FAIL rst_retry_req: req=%b stall=%b exp 1 0", dmem_req, mem_stall);
        end
        @(posedge clk); #1;
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL rst_retry_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int nreq;
        bit stopped;
        nreq    = 0;
        stopped = 0;
        drive_instr(32'h60, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        mdl_rdata = 32'hDEAD_BEEF;
        q.push_back('{alu: 32'h60, rd: 5'd4, rw: 1'b0, m2r: 1'b1, rdata: mdl_rdata});
        for (int c = 0; c < 40 && !stopped; c++) begin
            #3;
            if (dmem_req === 1'b1) nreq++;
            stopped = (mem_stall !== 1'b1);
            @(posedge clk); #1;
        end
        total++;
        if (!stopped || nreq != 16) begin
            bad++; $display("FAIL timeout_cycles: req cycles=%0d ended=%b exp 16 1", nreq, stopped);
        end
        drive_idle();
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL timeout_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dmem_err !== 1'b1 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL timeout_err: err=%b req=%b exp 1 0", dmem_err, dmem_req);
        end
        last_wb = exp_wb;
    endtask
`else
    task automatic test_long_wait();
        drive_instr(32'h64, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            #3;
            total++;
            if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
                bad++; $display("FAIL long_wait c%0d: req=%b stall=%b exp 1 1", c, dmem_req, mem_stall);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dmem_err !== 1'b0) begin
            bad++; $display("FAIL long_wait_err: got %b exp 0", dmem_err);
        end
        dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
        mdl_rdata = 32'h0BAD_F00D;
        q.push_back('{alu: 32'h64, rd: 5'd5, rw: 1'b1, m2r: 1'b1, rdata: mdl_rdata});
        @(posedge clk); #1;
        exp_wb = q.pop_front();
        total++;
        if (obs_wb() !== exp_wb) begin
            bad++; $display("FAIL long_wait_wb: got %h exp %h", obs_wb(), exp_wb);
        end
        last_wb = exp_wb;
        drive_idle();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_wait();
        test_store();
        test_branch();
        test_reset_mid_wait();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        @(posedge clk); #1;
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d entries left exp 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
